// File: rtl/udp_tx_sched_if.sv
// udp_tx_sched_if: the scheduler's two bus-side links, grouped for port use.
//   udp_tx link : udp_axiiv + latched header fields out, udp_axiov/udp_axiod/udp_last back
//   tx stream   : tx_valid / tx_data / tx_last, the outgoing UDP segment
// master = scheduler side, slave = the udp_tx instance plus downstream IP/MAC.
interface udp_tx_sched_if #(
    parameter int N = 2
);
    logic         udp_axiiv;
    logic [15:0]  udp_src_port;
    logic [15:0]  udp_dst_port;
    logic [15:0]  udp_length;
    logic [15:0]  udp_checksum;
    logic         udp_axiov;
    logic [N-1:0] udp_axiod;
    logic         udp_last;
    logic         tx_valid;
    logic [N-1:0] tx_data;
    logic         tx_last;

    modport master (
        output udp_axiiv, udp_src_port, udp_dst_port, udp_length, udp_checksum,
        input  udp_axiov, udp_axiod, udp_last,
        output tx_valid, tx_data, tx_last
    );

    modport slave (
        input  udp_axiiv, udp_src_port, udp_dst_port, udp_length, udp_checksum,
        output udp_axiov, udp_axiod, udp_last,
        input  tx_valid, tx_data, tx_last
    );
endinterface

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin arbiter sharing one udp_tx header generator
// between NUM_REQ payload sources. The winner's port/length/checksum fields
// are latched and held for udp_tx; the 8-byte header chunks coming back are
// forwarded, followed without a bubble by the winner's payload, forming one
// contiguous segment on tx_*.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req                 one request line per source, sampled only in IDLE
//   src_port, dst_port, data_length, data_checksum
//                       packed 16-bit fields, requester i at [16i+15:16i]
//   pay_valid, pay_data per-requester payload chunk stream (N bits each)
//   grant               one-hot, held for the whole frame
//   pay_phase           high while payload is consumed from the winner
//   underflow           one-cycle pulse when a frame is aborted in PAY
//   bus                 udp_tx link and outgoing tx stream (master side)
module udp_tx_sched #(
    parameter int N       = 2,
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] src_port,
    input  logic [16*NUM_REQ-1:0] dst_port,
    input  logic [16*NUM_REQ-1:0] data_length,
    input  logic [16*NUM_REQ-1:0] data_checksum,
    input  logic [NUM_REQ-1:0]    pay_valid,
    input  logic [N*NUM_REQ-1:0]  pay_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  pay_phase,
    output logic                  underflow,
    udp_tx_sched_if.master        bus
);
    localparam int          IW   = $clog2(NUM_REQ);
    localparam int          LOGN = $clog2(N);
    localparam logic [IW:0] NR   = (IW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] csum;
    } hdr_t;

    // per-requester views of the packed input buses
    logic [NUM_REQ-1:0][15:0]  src_a, dst_a, len_a, cks_a;
    logic [NUM_REQ-1:0][N-1:0] pd_a;

    assign src_a = src_port;
    assign dst_a = dst_port;
    assign len_a = data_length;
    assign cks_a = data_checksum;
    assign pd_a  = pay_data;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    hdr_t                 hdr_q, hdr_d;
    logic                 axiiv_q, axiiv_d;
    logic [18:0]          cnt_q, cnt_d;
    logic                 txv_q, txv_d;
    logic [N-1:0]         txd_q, txd_d;
    logic                 txl_q, txl_d;
    logic                 unf_q, unf_d;

    // payload chunk count: length bytes * 8/N, kept at full 19-bit width
    logic [18:0]          pay_chunks;
    assign pay_chunks = {hdr_q.len, 3'b000} >> LOGN;

    // round-robin pick: first set req bit starting at last+1, wrapping
    logic                 found;
    logic [IW-1:0]        win;
    logic [IW:0]          cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= NR) cand = cand - NR;
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    // next-state and next-output logic; every output is registered
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        hdr_d   = hdr_q;
        axiiv_d = axiiv_q;
        cnt_d   = cnt_q;
        txv_d   = 1'b0;
        txd_d   = '0;
        txl_d   = 1'b0;
        unf_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    hdr_d.src    = src_a[win];
                    hdr_d.dst    = dst_a[win];
                    hdr_d.len    = len_a[win];
                    hdr_d.csum   = cks_a[win];
                    axiiv_d      = 1'b1;
                    state_d      = HDR;
                end
            end
            HDR: begin
                txv_d = bus.udp_axiov;
                txd_d = bus.udp_axiod;
                if (bus.udp_axiov && bus.udp_last) begin
                    axiiv_d = 1'b0;
                    if (hdr_q.len == 16'd0) begin
                        // header-only segment: its last header chunk ends it
                        txl_d   = 1'b1;
                        state_d = GAP;
                    end else begin
                        cnt_d   = pay_chunks;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (pay_valid[gidx_q]) begin
                    txv_d = 1'b1;
                    txd_d = pd_a[gidx_q];
                    cnt_d = cnt_q - 19'd1;
                    if (cnt_q == 19'd1) begin
                        txl_d   = 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    // source starved: abort without tx_last so the frame is dropped
                    unf_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                grant_d = '0;
                cnt_d   = '0;
                last_d  = gidx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            hdr_q   <= '0;
            axiiv_q <= 1'b0;
            cnt_q   <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            txl_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            hdr_q   <= hdr_d;
            axiiv_q <= axiiv_d;
            cnt_q   <= cnt_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            txl_q   <= txl_d;
            unf_q   <= unf_d;
        end
    end

    assign grant            = grant_q;
    assign pay_phase        = (state_q == PAY);
    assign underflow        = unf_q;
    assign bus.udp_axiiv    = axiiv_q;
    assign bus.udp_src_port = hdr_q.src;
    assign bus.udp_dst_port = hdr_q.dst;
    assign bus.udp_length   = hdr_q.len;
    assign bus.udp_checksum = hdr_q.csum;
    assign bus.tx_valid     = txv_q;
    assign bus.tx_data      = txd_q;
    assign bus.tx_last      = txl_q;
endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: frame-level bench for udp_tx_sched (N=2, 4 requesters).
// A small udp_tx stand-in serialises the latched fields; the reference side
// predicts the winner from the round-robin rule and the full segment from the
// requester's fields and a deterministic payload pattern.
module tb_udp_tx_sched;
    localparam int N  = 2;
    localparam int NR = 4;
    localparam int HC = 64 / N;
    localparam int CB = 8 / N;
    localparam int OW = NR + N + 69;

    typedef struct {
        logic [NR-1:0] req;
        int            len;
        logic [15:0]   src;
        logic [15:0]   dst;
        int            drop;
        int            exp_g;
        bit            mut;
        bit            drop_req;
    } vec_t;

    logic                 clk, rst;
    logic [NR-1:0]        req;
    logic [NR-1:0][15:0]  f_src, f_dst, f_len, f_cs;
    logic [NR-1:0]        pv;
    logic [NR-1:0][N-1:0] pd;
    logic [NR-1:0]        grant;
    logic                 pay_phase, underflow;

    udp_tx_sched_if #(.N(N)) u ();

    udp_tx_sched #(.N(N), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .req(req),
        .src_port(f_src), .dst_port(f_dst), .data_length(f_len), .data_checksum(f_cs),
        .pay_valid(pv), .pay_data(pd),
        .grant(grant), .pay_phase(pay_phase), .underflow(underflow),
        .bus(u)
    );

    int n_tests = 0, n_fail = 0;
    int ref_last = NR - 1;
    int drop = -1;
    int pptr = 0;
    int hidx = 0;
    bit armed = 0;
    logic [N-1:0] cap[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int i, input int j);
        return 8'(i * 53 + j * 29 + 7) ^ 8'(j >> 2);
    endfunction

    function automatic logic [N-1:0] pay_chunk(input int i, input int k);
        logic [7:0] b;
        b = pay_byte(i, k / CB);
        return b[7 - N * (k % CB) -: N];
    endfunction

    function automatic logic [N-1:0] hdr_chunk(input logic [63:0] h, input int k);
        return h[63 - N * k -: N];
    endfunction

    function automatic int rr_ref(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (ref_last + k) % NR;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit outs_zero();
        logic [OW-1:0] v;
        v = {grant, pay_phase, underflow, u.udp_axiiv, u.udp_src_port, u.udp_dst_port,
             u.udp_length, u.udp_checksum, u.tx_valid, u.tx_data, u.tx_last};
        return (v === '0);
    endfunction

    // udp_tx stand-in: one idle cycle after enable, then 64/N header chunks MSB-first
    always @(negedge clk) begin
        if (!u.udp_axiiv) begin
            hidx = 0; armed = 0;
            u.udp_axiov = 1'b0; u.udp_last = 1'b0; u.udp_axiod = '0;
        end else if (!armed) begin
            armed = 1;
        end else if (hidx < HC) begin
            u.udp_axiov = 1'b1;
            u.udp_axiod = hdr_chunk({u.udp_src_port, u.udp_dst_port, u.udp_length, u.udp_checksum}, hidx);
            u.udp_last  = (hidx == HC - 1);
            hidx++;
        end else begin
            u.udp_axiov = 1'b0; u.udp_last = 1'b0;
        end
    end

    // payload sources: granted one streams its pattern, others emit noise
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (pay_phase && grant[i]) begin
                pv[i] = (pptr != drop);
                pd[i] = pay_chunk(i, pptr);
            end else begin
                pv[i] = 1'($urandom_range(0, 1));
                pd[i] = N'($urandom);
            end
        end
        if (pay_phase) pptr++;
        else pptr = 0;
    end

    task automatic load(input vec_t v);
        req  = v.req;
        drop = v.drop;
        for (int i = 0; i < NR; i++) begin
            f_src[i] = v.src + 16'(i);
            f_dst[i] = v.dst ^ 16'(i << 12);
            f_len[i] = 16'(v.len);
            f_cs[i]  = 16'hC000 + 16'(i * 16'h111) + v.src[7:0];
        end
    endtask

    task automatic run_frame(input vec_t v, input int exp_wait);
        int eg, waitc, cyc, nb, nlast, nunf, end_cyc, clr_cyc, lastpos, nmis, npay;
        bit started, ended, done, fld_bad, axi_bad, pp_seen;
        logic [63:0] hsnap;
        logic [N-1:0] exp_q[$];
        eg = (v.exp_g >= 0) ? v.exp_g : rr_ref(v.req);
        load(v);
        cap.delete();
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (grant == '0 && waitc < 20);
        chk("grant_seen", (grant != '0), 1);
        chk("grant_index", grant, 1 << eg);
        chk("axiiv_at_grant", u.udp_axiiv, 1);
        if (exp_wait >= 0) chk("frame_spacing", waitc, exp_wait);
        hsnap = {f_src[eg], f_dst[eg], f_len[eg], f_cs[eg]};
        for (int k = 0; k < HC; k++) exp_q.push_back(hdr_chunk(hsnap, k));
        npay = (v.drop >= 0) ? v.drop : v.len * CB;
        for (int k = 0; k < npay; k++) exp_q.push_back(pay_chunk(eg, k));
        cyc = 0; nb = 0; nlast = 0; nunf = 0; end_cyc = -1; clr_cyc = -2; lastpos = -1;
        started = 0; ended = 0; done = 0; fld_bad = 0; axi_bad = 0; pp_seen = 0;
        while (!done && cyc < 3000) begin
            if (grant != '0 &&
                {u.udp_src_port, u.udp_dst_port, u.udp_length, u.udp_checksum} !== hsnap)
                fld_bad = 1;
            if (v.mut && cyc == 6) begin
                f_dst[eg] = ~f_dst[eg];
                f_src[eg] = f_src[eg] + 16'd1;
            end
            if (v.drop_req && cyc == 3) req = '0;
            if (pay_phase) begin
                pp_seen = 1;
                if (u.udp_axiiv) axi_bad = 1;
            end
            if (grant == '0) begin
                clr_cyc = cyc;
                done = 1;
            end else begin
                if (u.tx_valid) begin
                    cap.push_back(u.tx_data);
                    started = 1;
                end else if (started && !ended && !underflow) nb++;
                if (u.tx_last) begin
                    nlast++; end_cyc = cyc; lastpos = cap.size(); ended = 1;
                end
                if (underflow) begin
                    nunf++; end_cyc = cyc; ended = 1;
                    if (u.tx_valid) axi_bad = 1;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("frame_done", done, 1);
        chk("stream_len", cap.size(), exp_q.size());
        nmis = 0;
        for (int k = 0; k < cap.size() && k < exp_q.size(); k++)
            if (cap[k] !== exp_q[k]) nmis++;
        chk("stream_data", nmis, 0);
        chk("tx_last_count", nlast, (v.drop < 0) ? 1 : 0);
        chk("underflow_count", nunf, (v.drop >= 0) ? 1 : 0);
        if (v.drop < 0) chk("tx_last_pos", lastpos, exp_q.size());
        chk("grant_clear", clr_cyc, end_cyc + 1);
        chk("bubbles", nb, 0);
        chk("pay_phase_seen", pp_seen, (v.len > 0) ? 1 : 0);
        chk("fields_held", fld_bad, 0);
        chk("axiiv_tx_rules", axi_bad, 0);
        ref_last = eg;
    endtask

    function automatic vec_t mkv(input logic [NR-1:0] r, input int len, input logic [15:0] s,
                                 input logic [15:0] d, input int dr, input int eg, input bit m);
        vec_t v;
        v.req = r; v.len = len; v.src = s; v.dst = d;
        v.drop = dr; v.exp_g = eg; v.mut = m; v.drop_req = 0;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t rv;
        tbl[0] = mkv(4'b0001, 4, 16'h1234, 16'h5678, -1, 0, 0);
        tbl[1] = mkv(4'b1111, 2, 16'h1111, 16'h2222, -1, 1, 0);
        tbl[2] = mkv(4'b1111, 2, 16'h3333, 16'h4444, -1, 2, 0);
        tbl[3] = mkv(4'b1111, 2, 16'h5555, 16'h6666, -1, 3, 0);
        tbl[4] = mkv(4'b1001, 1, 16'h7777, 16'h8888, -1, 0, 0);
        tbl[5] = mkv(4'b1001, 1, 16'h9999, 16'hAAAA, -1, 3, 0);
        tbl[6] = mkv(4'b0100, 0, 16'hBBBB, 16'hCCCC, -1, 2, 0);
        tbl[7] = mkv(4'b0010, 8, 16'hDDDD, 16'hEEEE,  4, 1, 0);
        tbl[8] = mkv(4'b0001, 3, 16'h0F0F, 16'hF0F0, -1, 0, 1);
        tbl[9] = mkv(4'b1111, 1, 16'hA5A5, 16'h5A5A, -1, 1, 0);

        req = '0; pv = '0; pd = '0; f_src = '0; f_dst = '0; f_len = '0; f_cs = '0;
        u.udp_axiov = 1'b0; u.udp_axiod = '0; u.udp_last = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset_outputs", outs_zero(), 1);
        repeat (3) @(negedge clk);
        chk("reset_hold_outputs", outs_zero(), 1);
        rst = 1'b1;

        for (int t = 0; t < 10; t++) run_frame(tbl[t], (t == 0) ? -1 : 1);

        // asynchronous reset in the middle of a payload
        load(mkv(4'b0001, 8, 16'h4321, 16'h8765, -1, 0, 0));
        for (int k = 0; k < 20 && grant == '0; k++) @(negedge clk);
        for (int k = 0; k < 100 && !pay_phase; k++) @(negedge clk);
        chk("reached_pay", pay_phase, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", outs_zero(), 1);
        @(negedge clk);
        chk("async_reset_hold", outs_zero(), 1);
        rst = 1'b1;
        ref_last = NR - 1;
        run_frame(mkv(4'b0011, 2, 16'h0102, 16'h0304, -1, 0, 0), -1);

        for (int t = 0; t < 40; t++) begin
            rv = mkv(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(0, 6),
                     16'($urandom), 16'($urandom), -1, -1, 0);
            if (rv.len > 0 && $urandom_range(0, 4) == 0)
                rv.drop = $urandom_range(0, rv.len * CB - 1);
            rv.drop_req = ($urandom_range(0, 3) == 0);
            run_frame(rv, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
